pc_fetch_ctrl: RTL

- Multi-cycle fetch sequencer that drives the program counter's load and PCSrc controls.
- Handshakes with instruction memory (req/ack) and with decode (valid/ready).
- Guarantees exactly one PC update per instruction accepted by decode, selecting PC+4 or PC+ImmExt from branch resolution.
- Also provides run/halt control, a fetch-timeout error and a retired-instruction counter.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_timer.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM state encoding,
// PC increment and PCSrc select values.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic        PCSRC_SEQ = 1'b0;
    localparam logic        PCSRC_BR  = 1'b1;

    // Wide enough for the largest legal timeout (255).
    localparam int unsigned TMR_W = 8;

    function automatic logic pick_pc_src(input logic br_valid, input logic br_taken);
        return (br_valid && br_taken) ? PCSRC_BR : PCSRC_SEQ;
    endfunction

    // Next-PC selection that the PC register performs from pc_src.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic [31:0] imm_ext,
                                            input logic        src);
        return (src == PCSRC_BR) ? pc + imm_ext : pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Loadable up-counter with clear and terminal-count flag, used to bound
// the wait for an instruction-memory acknowledge.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             inc,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Multi-cycle fetch sequencer: requests instructions, hands them to decode
// and pulses pc_load exactly once per accepted instruction.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             run,
    input  logic             halt,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             dec_ready,
    input  logic             br_valid,
    input  logic             br_taken,
    output logic             pc_load,
    output logic             pc_src,
    output logic             busy,
    output logic             err,
    output logic [RET_W-1:0] retired
);

    fetch_state_t state, state_nx;

    logic stop;
    logic hs;
    logic tmr_clear;
    logic tmr_inc;
    logic tmr_tc;

    // A dropped run is treated exactly like halt: honoured only at boundaries.
    assign stop = halt | ~run;
    assign hs   = (state == ST_ISSUE) & instr_valid & dec_ready;

    fetch_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .areset   (areset),
        .clear    (tmr_clear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (tmr_inc),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        tmr_clear = 1'b1;
        tmr_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!stop) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else begin
                    imem_req = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req  = 1'b1;
                tmr_clear = imem_ack;
                tmr_inc   = ~imem_ack;
                if (imem_ack)    state_nx = ST_ISSUE;
                else if (tmr_tc) state_nx = ST_ERR;
            end
            ST_ISSUE: begin
                if (hs) state_nx = stop ? ST_IDLE : ST_FETCH;
            end
            ST_ERR: begin
                state_nx = ST_ERR;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state       <= ST_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            retired     <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_WAIT) begin
                if (imem_ack) begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                end else if (tmr_tc) begin
                    err   <= 1'b1;
                    instr <= '0;
                end
            end
            if (hs) begin
                instr_valid <= 1'b0;
                retired     <= retired + RET_W'(1);
            end
        end
    end

    assign pc_load = hs;
    assign pc_src  = hs ? pick_pc_src(br_valid, br_taken) : PCSRC_SEQ;
    assign busy    = (state != ST_IDLE) && (state != ST_ERR);

endmodule
